// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: widths, reset defaults, fetch FSM encoding
// and the {instr, pc} payload carried between fetch and decode.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc} skid buffer; absorbs a response that arrives while
// decode is stalled on a full output register.
module if_skid_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  fetch_entry_t data_in,
    output fetch_entry_t data_out,
    output logic         valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            data_out <= '0;
        end else begin
            if (clear || unload) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end
            if (load && !clear) begin
                data_out <= data_in;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches and
// presents {instruction, pc} to decode through a registered output + skid.
module if_stage #(
    parameter int unsigned      XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = cpu_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     instruction,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid
);

    import cpu_pkg::*;

    fetch_state_e    state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] pc_req, pc_req_d;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_out_d;
    logic            valid_d;

    logic            skid_load, skid_unload, skid_clear, skid_valid;
    fetch_entry_t    skid_in, skid_out;

    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc & ~XLEN'(3);
    assign pc_plus4  = pc_out + XLEN'(4);
    assign skid_in   = '{instr: imem_rdata, pc: pc_req};

    if_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (skid_clear),
        .data_in  (skid_in),
        .data_out (skid_out),
        .valid    (skid_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pc_req      <= '0;
            instruction <= NOP_INSTR;
            pc_out      <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            pc_req      <= pc_req_d;
            instruction <= instr_d;
            pc_out      <= pc_out_d;
            instr_valid <= valid_d;
        end
    end

    // Next state, PC and output register; a held output stays valid, otherwise it bubbles.
    always_comb begin
        state_d     = state;
        pc_d        = pc;
        pc_req_d    = pc_req;
        instr_d     = instruction;
        pc_out_d    = pc_out;
        valid_d     = instr_valid && stall;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        case (state)
            FETCH: begin
                if (imem_gnt) begin
                    pc_req_d = pc;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    pc_d = pc_req + XLEN'(4);
                    if (!instr_valid || !stall) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_req;
                        valid_d  = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall && skid_valid) begin
                    instr_d     = skid_out.instr;
                    pc_out_d    = skid_out.pc;
                    valid_d     = 1'b1;
                    skid_unload = 1'b1;
                    state_d     = FETCH;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // Redirect flushes everything, even under stall; an in-flight fetch must be drained.
        if (redirect_valid) begin
            pc_d        = redirect_pc & ~XLEN'(3);
            instr_d     = instruction;
            pc_out_d    = pc_out;
            valid_d     = 1'b0;
            skid_load   = 1'b0;
            skid_unload = 1'b0;
            skid_clear  = 1'b1;
            case (state)
                FETCH:   state_d = imem_gnt ? DRAIN : FETCH;
                WAIT:    state_d = imem_rvalid ? FETCH : DRAIN;
                HOLD:    state_d = FETCH;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: program-order fetch/delivery reference model
// plus directed reset, wrap-around and async-reset scenarios.
module tb_if_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        imem_req, imem_gnt, imem_rvalid, stall, redirect_valid, instr_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, pc_out, pc_plus4;

    logic        w_req, w_gnt, w_rvalid, w_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc_out, w_pc_plus4;

    if_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instruction(instruction), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid)
    );

    if_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instruction(w_instr), .pc_out(w_pc_out), .pc_plus4(w_pc_plus4),
        .instr_valid(w_valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory responder: one outstanding request, 1..3 cycles gnt-to-rvalid.
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;

    task automatic mem_step(input bit allow_gnt);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (allow_gnt && imem_req && $urandom_range(0, 99) < 70) begin
            imem_gnt = 1'b1;
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(0, 2);
            mem_addr = imem_addr;
        end
    endtask

    logic [31:0] exp_fetch, exp_pc, prev_pc, prev_instr, prev_addr;
    bit          hold_prev, req_prev;
    int          n_retired, gap, max_gap;

    initial begin
        rst = 1'b1;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        stall = 0; redirect_valid = 0; redirect_pc = '0;
        w_gnt = 0; w_rvalid = 0; w_rdata = '0;

        #12;
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instruction, 32'h0000_0013);
        check("rst_pc_out", pc_out, 0);
        check("rst_pc_plus4", pc_plus4, 4);
        check("rst_addr", imem_addr, 0);

        // PC wrap-around on the second instance
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("wrap_req", w_req, 1);
        check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        w_gnt = 1'b1;
        @(negedge clk);
        w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        w_rvalid = 1'b0;
        check("wrap_valid", w_valid, 1);
        check("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", w_pc_plus4, 0);
        check("wrap_instr", w_instr, 32'hDEAD_BEEF);
        check("wrap_next_addr", w_addr, 0);

        // Randomized run against the program-order model
        exp_fetch = 0; exp_pc = 0;
        hold_prev = 0; req_prev = 0;
        n_retired = 0; gap = 0; max_gap = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (hold_prev) begin
                check("hold_valid", instr_valid, 1);
                check("hold_pc", pc_out, prev_pc);
                check("hold_instr", instruction, prev_instr);
            end
            if (req_prev) begin
                check("req_stable", imem_req, 1);
                check("addr_stable", imem_addr, prev_addr);
            end

            stall          = ($urandom_range(0, 99) < 35);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc    = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom();
            mem_step(1'b1);

            if (imem_req && imem_gnt) begin
                check("fetch_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (instr_valid && !stall) begin
                check("deliver_pc", pc_out, exp_pc);
                check("deliver_instr", instruction, mem_word(exp_pc));
                check("deliver_pc_plus4", pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_retired++;
                gap = 0;
            end else begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
            if (redirect_valid) begin
                exp_fetch = redirect_pc & ~32'd3;
                exp_pc    = redirect_pc & ~32'd3;
            end
            hold_prev  = instr_valid && stall && !redirect_valid;
            req_prev   = imem_req && !imem_gnt && !redirect_valid;
            prev_pc    = pc_out;
            prev_instr = instruction;
            prev_addr  = imem_addr;
        end
        check("progress", 32'(n_retired > 300), 1);
        check("max_gap", 32'(max_gap <= 100), 1);

        // Async reset in the middle of a fetch
        stall = 0; redirect_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_step(1'b0);
            if (imem_req && !mem_busy && !imem_rvalid) break;
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("ar_req_seen", imem_req, 1);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_valid", instr_valid, 0);
        check("ar_instr", instruction, 32'h0000_0013);
        check("ar_pc_out", pc_out, 0);
        check("ar_pc_plus4", pc_plus4, 4);
        check("ar_req", imem_req, 0);
        check("ar_addr", imem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("stale_valid", instr_valid, 0);
        check("restart_req", imem_req, 1);
        check("restart_addr", imem_addr, 0);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_word(0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("restart_valid", instr_valid, 1);
        check("restart_pc_out", pc_out, 0);
        check("restart_instr", instruction, mem_word(0));
        check("restart_next_addr", imem_addr, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
